// File: rtl/pipe_length_deframer_pkg.sv
// Shared types for the length-prefixed byte deframer: FSM state codes and the
// word carried through the output stage.
package pipe_length_deframer_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    PLD_HEADER  = 1'b0,
    PLD_PAYLOAD = 1'b1
  } pld_state_e;

  typedef struct packed {
    logic              start;
    logic              stop;
    logic [DATA_W-1:0] data;
  } pld_word_t;

endpackage

// File: rtl/pipe_length_deframer_out_reg.sv
// One-entry valid/ready output stage. Setting OutRegister to 0 turns it into a wire,
// which also makes the upstream ready a combinational copy of the downstream ready.
module pipe_length_deframer_out_reg
  import pipe_length_deframer_pkg::*;
#(
  parameter bit OutRegister = 1'b1
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      up_valid,
  input  pld_word_t up_word,
  output logic      up_ready,
  output logic      down_valid,
  output pld_word_t down_word,
  input  logic      down_ready
);

  generate
    if (OutRegister) begin : g_reg
      logic      valid_q;
      pld_word_t word_q;

      // The stage may take a new word whenever it is empty or its word leaves this cycle.
      assign up_ready   = ~valid_q | down_ready;
      assign down_valid = valid_q;
      assign down_word  = word_q;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          valid_q <= 1'b0;
          word_q  <= '0;
        end else if (up_valid && up_ready) begin
          valid_q <= 1'b1;
          word_q  <= up_word;
        end else if (down_ready) begin
          valid_q <= 1'b0;
        end
      end
    end else begin : g_bypass
      assign up_ready   = down_ready;
      assign down_valid = up_valid;
      assign down_word  = up_word;
    end
  endgenerate

endmodule

// File: rtl/pipe_length_deframer.sv
// Turns a raw byte stream of [N, N payload bytes] records into start/stop framed
// packets of the payload bytes. Header bytes are consumed and never forwarded.
//
// Handshake: on both pipes a byte moves on a rising edge where valid and ready are
// both high. valid never waits on ready; data/start/stop hold while valid & ~ready.
module pipe_length_deframer
  import pipe_length_deframer_pkg::*;
#(
  parameter bit OutRegister = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_in_valid,
  input  logic [DATA_W-1:0] pipe_in_data,
  output logic              pipe_in_ready,
  output logic              pipe_out_valid,
  output logic              pipe_out_start,
  output logic              pipe_out_stop,
  output logic [DATA_W-1:0] pipe_out_data,
  input  logic              pipe_out_ready,
  output logic              busy,
  output logic              pkt_done,
  output logic              zero_len,
  output pld_state_e        fsm_state
);

  pld_state_e        state_q, state_d;
  logic [DATA_W-1:0] remaining_q, remaining_d;
  logic              first_q, first_d;
  logic              zero_len_q, zero_len_d;

  logic      stage_valid;
  logic      stage_ready;
  pld_word_t stage_word;
  pld_word_t out_word;

  assign stage_word = '{start: first_q, stop: (remaining_q == 8'd1), data: pipe_in_data};

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    first_d       = first_q;
    zero_len_d    = 1'b0;
    pipe_in_ready = stage_ready;
    stage_valid   = 1'b0;
    case (state_q)
      PLD_HEADER: begin
        pipe_in_ready = 1'b1;
        if (pipe_in_valid) begin
          if (pipe_in_data == '0) begin
            zero_len_d = 1'b1;
          end else begin
            remaining_d = pipe_in_data;
            first_d     = 1'b1;
            state_d     = PLD_PAYLOAD;
          end
        end
      end
      PLD_PAYLOAD: begin
        stage_valid = pipe_in_valid;
        if (pipe_in_valid && stage_ready) begin
          first_d     = 1'b0;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = PLD_HEADER;
        end
      end
      default: state_d = PLD_HEADER;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= PLD_HEADER;
      remaining_q <= '0;
      first_q     <= 1'b0;
      zero_len_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      zero_len_q  <= zero_len_d;
    end
  end

  pipe_length_deframer_out_reg #(
    .OutRegister(OutRegister)
  ) u_out_reg (
    .clock      (clock),
    .reset      (reset),
    .up_valid   (stage_valid),
    .up_word    (stage_word),
    .up_ready   (stage_ready),
    .down_valid (pipe_out_valid),
    .down_word  (out_word),
    .down_ready (pipe_out_ready)
  );

  assign pipe_out_start = out_word.start;
  assign pipe_out_stop  = out_word.stop;
  assign pipe_out_data  = out_word.data;

  // Completion follows the sink taking the stop word, not the input side.
  assign pkt_done  = pipe_out_valid & pipe_out_ready & pipe_out_stop;
  assign busy      = (state_q == PLD_PAYLOAD);
  assign zero_len  = zero_len_q;
  assign fsm_state = state_q;

endmodule
